// File: rtl/ntt_reader_pkg.sv
// Shared types and default parameters for the NTT coefficient read engine:
// FSM states, parameter defaults and the read tag carried alongside the RAM pipe.
package ntt_reader_pkg;

  localparam int DW_DEF     = 12;
  localparam int N_DEF      = 256;
  localparam int NBANK_DEF  = 4;
  localparam int STAGES_DEF = 7;
  localparam int RD_LAT_DEF = 2;

  localparam int TAG_SW = $clog2(STAGES_DEF);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_SW-1:0] stage;
    logic              last;
  } tag_t;

endpackage

// File: rtl/ntt_reader_fifo.sv
// Small synchronous FIFO with occupancy count; the head entry is presented
// straight from the storage registers so the consumer sees a registered value.
module ntt_reader_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state is only ever updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset on purpose so the data outputs read zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  // Writing into a full FIFO is only safe when the head leaves in the same cycle.
  wr_full_a: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full && !rd_en));
  rd_empty_a: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty));

endmodule

// File: rtl/ntt_coef_reader.sv
// Stage-ordered row reader for the NTT coefficient banks with credit-based issue.
// Define READER_PERF_EN to build the output back-pressure stall counter.
module ntt_coef_reader
  import ntt_reader_pkg::*;
#(
  parameter  int DW        = DW_DEF,
  parameter  int N         = N_DEF,
  parameter  int NBANK     = NBANK_DEF,
  parameter  int STAGES    = STAGES_DEF,
  parameter  int RD_LAT    = RD_LAT_DEF,
  localparam int ROWS      = N / NBANK,
  localparam int AW        = $clog2(ROWS),
  localparam int SW        = $clog2(STAGES),
  localparam int BUF_DEPTH = RD_LAT + 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [NBANK*DW-1:0] rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NBANK*DW-1:0] out_data,
  output logic [SW-1:0]       out_stage,
  output logic                out_last,
  output logic [15:0]         perf_stall_cnt
);

  localparam int RW = NBANK * DW;
  localparam int FW = RW + SW + 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q;
  logic [AW-1:0] cnt_q;
  tag_t          tag_pipe [RD_LAT];
  tag_t          tag_in;
  tag_t          tag_out;
  int            inflight;
  logic          credit_ok;
  logic          issue;
  logic          last_issue;
  logic          accept;
  logic          final_beat;
  logic          start_ok;

  logic [FW-1:0] fifo_wdata;
  logic [FW-1:0] fifo_rdata;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  function automatic logic [AW-1:0] rotl(input logic [AW-1:0] v, input int r);
    logic [2*AW-1:0] dbl;
    dbl = {v, v} << r;
    return dbl[2*AW-1:AW];
  endfunction

  // Reads in the tag pipe still owe a FIFO slot; reserve it before issuing.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight += int'(tag_pipe[i].valid);
  end

  assign credit_ok  = (int'(fifo_count) + inflight + 1) <= BUF_DEPTH;
  assign issue      = (state_q == ISSUE) && credit_ok;
  assign last_issue = (stage_q == SW'(STAGES - 1)) && (cnt_q == AW'(ROWS - 1));
  assign start_ok   = (state_q == IDLE) && start;

  assign rd_en   = issue;
  assign rd_addr = rotl(cnt_q, int'(stage_q) % AW);

  always_comb begin
    tag_in       = '0;
    tag_in.valid = issue;
    tag_in.stage = TAG_SW'(stage_q);
    tag_in.last  = (cnt_q == AW'(ROWS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) tag_pipe[i] <= tag_pipe[i-1];
      tag_pipe[0] <= tag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else if (start_ok) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else if (issue) begin
      if (cnt_q == AW'(ROWS - 1)) begin
        cnt_q   <= '0;
        stage_q <= stage_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign tag_out    = tag_pipe[RD_LAT-1];
  assign fifo_wdata = {SW'(tag_out.stage), tag_out.last, rd_data};

  ntt_reader_fifo #(
    .WIDTH (FW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tag_out.valid),
    .wr_data (fifo_wdata),
    .rd_en   (accept),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_rdata[RW-1:0];
  assign out_last   = fifo_rdata[RW];
  assign out_stage  = fifo_rdata[FW-1 -: SW];
  assign accept     = out_valid && out_ready;
  assign final_beat = accept && out_last && (out_stage == SW'(STAGES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (issue && last_issue) state_d = DRAIN;
      DRAIN:   if (final_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == DONE);

`ifdef READER_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (busy && out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/ntt_coef_reader.md
Name: ntt_coef_reader

Overview:
- Read-side engine for the polynomial coefficient banks of the radix-2, 4-BFU NTT datapath; counterpart to the bank write path.
- On `start`, walks every row of the NBANK-wide coefficient memory once per NTT stage, in a stage-dependent order.
- Absorbs the fixed RAM read latency and presents rows to the butterfly feed through a valid/ready stream.
- Stalls memory issue under back-pressure so no row is ever dropped.

Parameters:
- DW, 12, coefficient width in bits (Kyber q=3329).
- N, 256, polynomial length.
- NBANK, 4, banks read in parallel; one coefficient per bank per row.
- STAGES, 7, NTT stages walked per run.
- RD_LAT, 2, cycles from `rd_en` to valid `rd_data`; legal range 1..4.
- Derived: ROWS = N/NBANK; AW = clog2(ROWS); SW = clog2(STAGES); BUF_DEPTH = RD_LAT+2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- start  in  1  single-cycle run request
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- rd_en  out  1  memory read strobe
- rd_addr  out  AW  row address
- rd_data  in  NBANK*DW  row data, valid RD_LAT cycles after `rd_en`
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  NBANK*DW  row coefficients, bank 0 in LSBs
- out_stage  out  SW  stage index of the beat
- out_last  out  1  last row of the current stage
- perf_stall_cnt  out  16  stall counter; see Optional Feature

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters, tag pipe and FIFO cleared. Reset mid-run aborts immediately; in-flight `rd_data` is discarded.
- FSM:
  - IDLE: `start` -> ISSUE; clear stage s and row cnt.
  - ISSUE: issue reads until s=STAGES-1 and cnt=ROWS-1 have been issued -> DRAIN.
  - DRAIN: wait until the final beat is accepted -> DONE.
  - DONE: one cycle -> IDLE.
- Handshake flags: `busy`=1 in ISSUE/DRAIN. `done`=1 only in the DONE state, with `busy`=0 in that cycle. `start` while not IDLE is ignored.
- Addressing: `rd_addr` = rotl(cnt, s mod AW) within AW bits. cnt increments per issued read; at ROWS-1 it wraps to 0 and s increments.
- Credit rule: `rd_en` asserts in ISSUE only when fifo_count + inflight + 1 <= BUF_DEPTH. inflight is the number of reads whose data is not yet written to the FIFO.
- Tag pipe: an RD_LAT-deep shift register of {valid, s, last} runs parallel to the RAM. `rd_data` is written to the FIFO with its tag when the tag pipe's valid output is 1.
- FIFO: synchronous, BUF_DEPTH entries. `out_*` is registered from the FIFO head; a beat transfers when `out_valid`&`out_ready`. Simultaneous write and read at full is legal, since credits guarantee no overflow. Writes while full or reads while empty are assertion failures.
- Latency: `start` sampled at edge T -> first `rd_en` in cycle T+1 -> `rd_data` at T+1+RD_LAT -> `out_valid` at T+2+RD_LAT.
- Throughput: with `out_ready` held high, one beat per cycle sustained; total beats = STAGES*ROWS.
- Ordering: `out_last`=1 exactly on cnt=ROWS-1 beats. `out_valid`, `out_data`, `out_stage` and `out_last` hold stable while `out_valid`&!`out_ready`.

Optional Feature:
- READER_PERF_EN defined: `perf_stall_cnt` counts cycles with `busy`&`out_valid`&!`out_ready`. It saturates at 16'hFFFF and clears on `start` acceptance and on reset.
- Undefined: `perf_stall_cnt` is tied to 0 and no counter logic is built.

Decomposition:
- Package ntt_reader_pkg holds:
  - FSM state enum {IDLE, ISSUE, DRAIN, DONE};
  - defaults for DW/N/NBANK/STAGES/RD_LAT;
  - the tag struct {valid, stage, last}.
- One sub-module, ntt_reader_fifo: parameterised width/depth synchronous FIFO with count output.

Test Plan:
- Defaults, `out_ready`=1, `start` at T -> first `out_valid` at T+4, 448 contiguous beats, `done` 1 cycle after beat 447, `busy` low with `done`.
- Stage 1 walk: cnt=1 -> `rd_addr`=2; stage 0 cnt=63 -> `rd_addr`=63; `out_last` on beats 63, 127, ..., 447 only.
- `out_ready` random 50% -> no loss, duplication or reordering vs memory model; `rd_en` never asserts when credits = 0.
- `out_ready`=0 for 20 cycles mid-stage -> `rd_en` stops after 4 outstanding; output beat held stable; resumes in order.
- `rst_n` low for 1 cycle at beat 100 -> all outputs 0, FSM IDLE; a new `start` gives a clean full 448-beat run.
- With READER_PERF_EN, 20-cycle stall -> `perf_stall_cnt`=20; next `start` -> 0.
